// File: rtl/cnn_pkg.sv
// Shared constants for the CNN input-feature-map path: packed-word marker
// positions, default widths and the row-packer state encoding.
package cnn_pkg;

  localparam int DEF_IFMAP_BUFFER_WIDTH = 18;
  localparam int DEF_LEN_WIDTH          = 5;
  localparam int DEF_ROWS_WIDTH         = 8;

  // Start-of-row and end-of-row marker bits inside a packed word.
  localparam int SOR_BIT = 17;
  localparam int EOR_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/out_skid_reg.sv
// Single-entry output holding register: keeps its word stable while the
// consumer is full and accepts a new word whenever it is empty or draining.
module out_skid_reg #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             full,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             can_load
);

  logic drain;

  assign drain    = valid && !full;
  assign can_load = !valid || drain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifmap_row_packer.sv
// Streams a job of row_count x row_length pixels into marker-tagged words,
// then appends a zero-data flush row of filter_size words.
module ifmap_row_packer
  import cnn_pkg::*;
#(
  parameter int IFMAP_BUFFER_WIDTH = DEF_IFMAP_BUFFER_WIDTH,
  parameter int DATA_WIDTH         = IFMAP_BUFFER_WIDTH - 2,
  parameter int LEN_WIDTH          = DEF_LEN_WIDTH,
  parameter int ROWS_WIDTH         = DEF_ROWS_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          row_length,
  input  logic [ROWS_WIDTH-1:0]         row_count,
  input  logic [LEN_WIDTH-1:0]          filter_size,
  input  logic [DATA_WIDTH-1:0]         pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in,
  output logic                          IFmap_buffer_write_enable,
  input  logic                          IFmap_buffer_full,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    fsm_state
);

  // Handshakes: a pixel moves on a clock edge where pix_valid && pix_ready;
  // a word moves on an edge where IFmap_buffer_write_enable && !IFmap_buffer_full.

  state_t                  state;
  logic [LEN_WIDTH-1:0]    len_q, fsz_q, col;
  logic [ROWS_WIDTH-1:0]   rows_q, row;
  logic                    flush_loaded;
  logic                    can_load, load, pix_fire, flush_fire, drain;
  logic                    last_col, last_flush;
  logic [IFMAP_BUFFER_WIDTH-1:0] word;

  assign pix_ready  = (state == RUN) && can_load;
  assign pix_fire   = pix_valid && pix_ready;
  assign flush_fire = (state == FLUSH) && !flush_loaded && can_load;
  assign load       = pix_fire || flush_fire;
  assign drain      = IFmap_buffer_write_enable && !IFmap_buffer_full;
  assign last_col   = (col == len_q - LEN_WIDTH'(1));
  assign last_flush = (col == fsz_q - LEN_WIDTH'(1));

  // The column counter is reused as the flush-word index.
  always_comb begin
    word = '0;
    word[SOR_BIT] = (col == '0);
    if (state == FLUSH) begin
      word[EOR_BIT] = last_flush;
    end else begin
      word[EOR_BIT] = last_col;
      word[DATA_WIDTH-1:0] = pix_in;
    end
  end

  out_skid_reg #(
    .WIDTH(IFMAP_BUFFER_WIDTH)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .din      (word),
    .full     (IFmap_buffer_full),
    .dout     (IFmap_buffer_in),
    .valid    (IFmap_buffer_write_enable),
    .can_load (can_load)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      len_q        <= '0;
      rows_q       <= '0;
      fsz_q        <= '0;
      col          <= '0;
      row          <= '0;
      flush_loaded <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && row_length != '0 && row_count != '0 && filter_size != '0) begin
            len_q        <= row_length;
            rows_q       <= row_count;
            fsz_q        <= filter_size;
            col          <= '0;
            row          <= '0;
            flush_loaded <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (pix_fire) begin
            if (last_col) begin
              col <= '0;
              if (row == rows_q - ROWS_WIDTH'(1)) begin
                row   <= '0;
                state <= FLUSH;
              end else begin
                row <= row + ROWS_WIDTH'(1);
              end
            end else begin
              col <= col + LEN_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_fire) begin
            if (last_flush) flush_loaded <= 1'b1;
            else            col <= col + LEN_WIDTH'(1);
          end
          // Once the last flush word is in the register, its drain ends the job.
          if (flush_loaded && drain) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Randomised scoreboard bench for ifmap_row_packer: a job-level model fills an
// expected-word queue, and a negedge monitor checks every consumed word.
module tb_ifmap_row_packer;
  import cnn_pkg::*;

  localparam int W  = 18;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] row_length = '0;
  logic [RW-1:0] row_count = '0;
  logic [LW-1:0] filter_size = '0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [W-1:0]  dout;
  logic          we;
  logic          full = 1'b0;
  logic          busy, done;
  logic [1:0]    fsm_state;

  ifmap_row_packer dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .row_length                (row_length),
    .row_count                 (row_count),
    .filter_size               (filter_size),
    .pix_in                    (pix_in),
    .pix_valid                 (pix_valid),
    .pix_ready                 (pix_ready),
    .IFmap_buffer_in           (dout),
    .IFmap_buffer_write_enable (we),
    .IFmap_buffer_full         (full),
    .busy                      (busy),
    .done                      (done),
    .fsm_state                 (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] pix_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  int done_cnt = 0;
  bit prev_done = 1'b0;
  bit prev_hold = 1'b0;
  logic [W-1:0] held_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Job-level reference: every row is row_length pixels in arrival order with
  // SOR on column 0 and EOR on the last column, then one zero row of filter_size.
  task automatic push_expected(input int len, input int rows, input int fsz);
    logic [W-1:0] w;
    int k = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        w = '0;
        w[SOR_BIT] = (c == 0);
        w[EOR_BIT] = (c == len - 1);
        w[DW-1:0]  = pix_q[k];
        exp_q.push_back(w);
        k++;
      end
    end
    for (int f = 0; f < fsz; f++) begin
      w = '0;
      w[SOR_BIT] = (f == 0);
      w[EOR_BIT] = (f == fsz - 1);
      exp_q.push_back(w);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (prev_hold) begin
        check("hold_we", we, 1);
        check("hold_word", dout, held_word);
      end
      if (we && full) check("stall_ready", pix_ready, 0);
      prev_hold = we && full;
      held_word = dout;
      if (we && !full && mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=%0h required=none", dout);
        end else begin
          check("word", dout, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (mon_en) check("done_queue_empty", exp_q.size(), 0);
        check("done_single_cycle", prev_done, 0);
      end
      prev_done = done;
    end else begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge that follows done.
  task automatic run_job(input int len, input int rows, input int fsz, input bit seq,
                         input int valid_pct, input int full_pct,
                         input int stall_at, input int restart_at);
    int cyc = 0;
    int start_cnt;
    bit fire;
    pix_q.delete();
    for (int n = 0; n < len * rows; n++)
      pix_q.push_back(seq ? DW'(n + 1) : DW'($urandom));
    push_expected(len, rows, fsz);
    start_cnt   = done_cnt;
    start       = 1'b1;
    row_length  = LW'(len);
    row_count   = RW'(rows);
    filter_size = LW'(fsz);
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == start_cnt && cyc < 3000) begin
      if (cyc == restart_at) begin
        start       = 1'b1;
        row_length  = LW'($urandom_range(31, 1));
        row_count   = RW'($urandom_range(255, 1));
        filter_size = LW'($urandom_range(31, 1));
      end else begin
        start       = 1'b0;
        row_length  = LW'($urandom);
        row_count   = RW'($urandom);
        filter_size = LW'($urandom);
      end
      pix_valid = (pix_q.size() > 0) && ($urandom_range(99) < valid_pct);
      pix_in    = pix_valid ? pix_q[0] : DW'($urandom);
      full      = (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) ||
                  ($urandom_range(99) < full_pct);
      @(negedge clk);
      fire = pix_valid && pix_ready;
      if (pix_q.size() == 0) check("ready_after_last_pixel", pix_ready, 0);
      @(posedge clk);
      if (fire) void'(pix_q.pop_front());
      #1;
      cyc++;
    end
    if (done_cnt == start_cnt) begin
      checks++;
      errors++;
      $display("FAIL job_timeout actual=no_done required=done len=%0d rows=%0d fsz=%0d",
               len, rows, fsz);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    full = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_done", busy, 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_data", dout, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Start asserted during reset must not launch a job.
    start = 1'b1; row_length = 5'd4; row_count = 8'd2; filter_size = 5'd4;
    @(posedge clk); #1;
    check("rst_over_start_busy", busy, 0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic 4x2 job, filter 4, pixels 1..8, no back-pressure.
    run_job(4, 2, 4, 1'b1, 100, 0, -1, -1);
    // Same job with a 5-cycle full stall mid-row.
    run_job(4, 2, 4, 1'b1, 100, 0, 2, -1);
    // Single-pixel rows and a single-word flush row.
    run_job(1, 3, 1, 1'b0, 100, 0, -1, -1);

    // Zero-valued launch parameters are ignored.
    for (int z = 0; z < 3; z++) begin
      start       = 1'b1;
      row_length  = (z == 0) ? 5'd0 : 5'd3;
      row_count   = (z == 1) ? 8'd0 : 8'd2;
      filter_size = (z == 2) ? 5'd0 : 5'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check("zero_param_busy", busy, 0);
      @(posedge clk); #1;
      check("zero_param_busy_later", busy, 0);
    end

    // A second start mid-run must not change the sampled parameters.
    run_job(3, 2, 2, 1'b0, 100, 0, -1, 2);

    // Reset while flushing: no word and no busy on the next cycle.
    mon_en = 1'b0;
    start = 1'b1; row_length = 5'd2; row_count = 8'd1; filter_size = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = 1'b1;
    pix_in = 16'h1234;
    budget = 0;
    while (fsm_state != 2'd2 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    pix_valid = 1'b0;
    check("reached_flush", fsm_state, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("flush_reset_we", we, 0);
    check("flush_reset_busy", busy, 0);
    check("flush_reset_ready", pix_ready, 0);
    reset = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_job(4, 2, 4, 1'b1, 100, 0, -1, -1);

    // Random jobs: random pixel gaps, some with random back-pressure.
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(6, 1), $urandom_range(4, 1), $urandom_range(5, 1), 1'b0,
              $urandom_range(90, 30), (j < 5) ? 0 : 30, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
